// File: rtl/wb_gain_ctrl.sv
// Gray-world white-balance gains k/avg_c from one shared restoring divider; 66 cycles sum_valid->pending.
// No backpressure: a sum_valid arriving while busy is dropped and flagged in the sticky o_overrun.
module wb_gain_ctrl #(
  parameter int SUM_W     = 28,
  parameter int TRIM_BITS = 20,
  parameter int FRAC_BITS = 8,
  parameter int GAIN_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vsync,
  input  logic              i_sum_valid,
  input  logic [SUM_W-1:0]  i_r_sum,
  input  logic [SUM_W-1:0]  i_g_sum,
  input  logic [SUM_W-1:0]  i_b_sum,
  input  logic              i_bypass,
  output logic [GAIN_W-1:0] o_r_gain,
  output logic [GAIN_W-1:0] o_g_gain,
  output logic [GAIN_W-1:0] o_b_gain,
  output logic              o_busy,
  output logic              o_pending,
  output logic              o_overrun
);

  localparam int DIV_W = 8 + FRAC_BITS;
  localparam int CNT_W = $clog2(DIV_W);
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1 << FRAC_BITS);
  localparam logic [GAIN_W-1:0] GMAX  = '1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIV_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LATCH, ST_DIV_K, ST_DIV_R, ST_DIV_G, ST_DIV_B, ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        rem_q, rem_d;
  logic [DIV_W-1:0]  quo_q, quo_d;
  logic [7:0]        k_q, k_d;
  logic [7:0]        avg_r_q, avg_r_d, avg_g_q, avg_g_d, avg_b_q, avg_b_d;
  logic [GAIN_W-1:0] res_r_q, res_r_d, res_g_q, res_g_d, res_b_q, res_b_d;
  logic [GAIN_W-1:0] shd_r_q, shd_r_d, shd_g_q, shd_g_d, shd_b_q, shd_b_d;
  logic [GAIN_W-1:0] gain_r_q, gain_r_d, gain_g_q, gain_g_d, gain_b_q, gain_b_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              vsync_q;

  logic [SUM_W-1:0]  r_sh, g_sh, b_sh;
  logic [7:0]        divisor;
  logic [8:0]        rem_sh, diff;
  logic              ge;
  logic [DIV_W-1:0]  quo_nx, quo_hi;
  logic [GAIN_W-1:0] q_sat;
  logic [9:0]        sum_s;
  logic              busy, vs_rise, last;

  assign r_sh = i_r_sum >> TRIM_BITS;
  assign g_sh = i_g_sum >> TRIM_BITS;
  assign b_sh = i_b_sum >> TRIM_BITS;

  assign busy    = (state_q != ST_IDLE);
  assign vs_rise = i_vsync & ~vsync_q;
  assign last    = (cnt_q == LAST);

  // One restoring-divide step: shift in the next numerator bit, subtract if it fits.
  always_comb begin
    case (state_q)
      ST_DIV_K: divisor = 8'd3;
      ST_DIV_R: divisor = avg_r_q;
      ST_DIV_G: divisor = avg_g_q;
      default:  divisor = avg_b_q;
    endcase
    rem_sh = {rem_q, quo_q[DIV_W-1]};
    diff   = rem_sh - {1'b0, divisor};
    ge     = (rem_sh >= {1'b0, divisor});
    quo_nx = {quo_q[DIV_W-2:0], ge};
    quo_hi = quo_nx >> GAIN_W;
    q_sat  = ((divisor == 8'd0) || (quo_hi != '0)) ? GMAX : quo_nx[GAIN_W-1:0];
    sum_s  = 10'(avg_r_q) + 10'(avg_g_q) + 10'(avg_b_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    k_d       = k_q;
    avg_r_d   = avg_r_q;
    avg_g_d   = avg_g_q;
    avg_b_d   = avg_b_q;
    res_r_d   = res_r_q;
    res_g_d   = res_g_q;
    res_b_d   = res_b_q;
    shd_r_d   = shd_r_q;
    shd_g_d   = shd_g_q;
    shd_b_d   = shd_b_q;
    gain_r_d  = gain_r_q;
    gain_g_d  = gain_g_q;
    gain_b_d  = gain_b_q;
    pending_d = pending_q;
    overrun_d = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (i_sum_valid) begin
          avg_r_d = r_sh[7:0];
          avg_g_d = g_sh[7:0];
          avg_b_d = b_sh[7:0];
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        quo_d   = DIV_W'(sum_s);
        rem_d   = 8'd0;
        cnt_d   = '0;
        state_d = ST_DIV_K;
      end
      ST_DIV_K, ST_DIV_R, ST_DIV_G, ST_DIV_B: begin
        rem_d = ge ? diff[7:0] : rem_sh[7:0];
        quo_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          cnt_d = '0;
          rem_d = 8'd0;
          // Each finished divide reloads the numerator k<<FRAC_BITS for the next channel.
          quo_d = {k_q, {FRAC_BITS{1'b0}}};
          case (state_q)
            ST_DIV_K: begin
              k_d     = quo_nx[7:0];
              quo_d   = {quo_nx[7:0], {FRAC_BITS{1'b0}}};
              state_d = ST_DIV_R;
            end
            ST_DIV_R: begin
              res_r_d = q_sat;
              state_d = ST_DIV_G;
            end
            ST_DIV_G: begin
              res_g_d = q_sat;
              state_d = ST_DIV_B;
            end
            default: begin
              res_b_d = q_sat;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_DONE: begin
        shd_r_d = res_r_q;
        shd_g_d = res_g_q;
        shd_b_d = res_b_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_sum_valid && busy) overrun_d = 1'b1;

    if (vs_rise) begin
      if (pending_q) begin
        gain_r_d  = i_bypass ? UNITY : shd_r_q;
        gain_g_d  = i_bypass ? UNITY : shd_g_q;
        gain_b_d  = i_bypass ? UNITY : shd_b_q;
        pending_d = 1'b0;
      end else if (i_bypass) begin
        gain_r_d = UNITY;
        gain_g_d = UNITY;
        gain_b_d = UNITY;
      end
    end

    // A set finished this cycle stays pending even if an edge arrived alongside it.
    if (state_q == ST_DONE) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= 8'd0;
      quo_q     <= '0;
      k_q       <= 8'd0;
      avg_r_q   <= 8'd0;
      avg_g_q   <= 8'd0;
      avg_b_q   <= 8'd0;
      res_r_q   <= UNITY;
      res_g_q   <= UNITY;
      res_b_q   <= UNITY;
      shd_r_q   <= UNITY;
      shd_g_q   <= UNITY;
      shd_b_q   <= UNITY;
      gain_r_q  <= UNITY;
      gain_g_q  <= UNITY;
      gain_b_q  <= UNITY;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      vsync_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      k_q       <= k_d;
      avg_r_q   <= avg_r_d;
      avg_g_q   <= avg_g_d;
      avg_b_q   <= avg_b_d;
      res_r_q   <= res_r_d;
      res_g_q   <= res_g_d;
      res_b_q   <= res_b_d;
      shd_r_q   <= shd_r_d;
      shd_g_q   <= shd_g_d;
      shd_b_q   <= shd_b_d;
      gain_r_q  <= gain_r_d;
      gain_g_q  <= gain_g_d;
      gain_b_q  <= gain_b_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      vsync_q   <= i_vsync;
    end
  end

  assign o_r_gain  = gain_r_q;
  assign o_g_gain  = gain_g_q;
  assign o_b_gain  = gain_b_q;
  assign o_busy    = busy;
  assign o_pending = pending_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_wb_gain_ctrl.sv
// Randomized bench for wb_gain_ctrl against a plain-arithmetic gray-world gain model.
module tb_wb_gain_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_vsync, i_sum_valid, i_bypass;
  logic [27:0] i_r_sum, i_g_sum, i_b_sum;
  logic [11:0] o_r_gain, o_g_gain, o_b_gain;
  logic        o_busy, o_pending, o_overrun;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: applied gains, shadow set, pending and overrun flags.
  int app_r = 256, app_g = 256, app_b = 256;
  int shd_r, shd_g, shd_b;
  bit mdl_pend = 0, mdl_ovr = 0;

  wb_gain_ctrl dut (
    .clk(clk), .rst(rst), .i_vsync(i_vsync), .i_sum_valid(i_sum_valid),
    .i_r_sum(i_r_sum), .i_g_sum(i_g_sum), .i_b_sum(i_b_sum), .i_bypass(i_bypass),
    .o_r_gain(o_r_gain), .o_g_gain(o_g_gain), .o_b_gain(o_b_gain),
    .o_busy(o_busy), .o_pending(o_pending), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gain_of(input int avg, input int k);
    int q;
    if (avg == 0) return 4095;
    q = (k * 256) / avg;
    return (q > 4095) ? 4095 : q;
  endfunction

  function automatic logic [27:0] mk_sum(input int avg);
    return (28'(avg) << 20) | 28'($urandom_range(0, (1 << 20) - 1));
  endfunction

  task automatic chk_gains(input string tag);
    chk({tag, "_r"}, o_r_gain, app_r);
    chk({tag, "_g"}, o_g_gain, app_g);
    chk({tag, "_b"}, o_b_gain, app_b);
  endtask

  // Called mid-cycle; the valid pulse occupies the current cycle (cycle 0).
  task automatic run_frame(input int r, input int g, input int b, input int ovr_cyc,
                           input bit vs_on_done);
    int k;
    k = (r + g + b) / 3;
    i_r_sum = mk_sum(r); i_g_sum = mk_sum(g); i_b_sum = mk_sum(b);
    i_sum_valid = 1'b1;
    for (int c = 1; c <= 67; c++) begin
      @(negedge clk);
      if (c == 1) i_sum_valid = 1'b0;
      chk($sformatf("busy_c%0d", c), o_busy, (c <= 66) ? 1 : 0);
      if (c == 66) chk("pend_before_done", o_pending, mdl_pend);
      if (c == ovr_cyc) begin
        i_r_sum = mk_sum(255); i_g_sum = mk_sum(1); i_b_sum = mk_sum(7);
        i_sum_valid = 1'b1;
        mdl_ovr = 1'b1;
      end
      if (c == ovr_cyc + 1) i_sum_valid = 1'b0;
      if (c == 66 && vs_on_done) i_vsync = 1'b1;
    end
    i_vsync = 1'b0;
    shd_r = gain_of(r, k); shd_g = gain_of(g, k); shd_b = gain_of(b, k);
    mdl_pend = 1'b1;
    chk("pend_at_67", o_pending, 1);
    chk("overrun", o_overrun, mdl_ovr);
    chk_gains("held_at_67");
  endtask

  task automatic commit(input bit byp);
    i_vsync = 1'b0;
    @(negedge clk);
    chk_gains("pre_commit");
    i_vsync = 1'b1;
    i_bypass = byp;
    @(negedge clk);
    if (mdl_pend) begin
      app_r = byp ? 256 : shd_r; app_g = byp ? 256 : shd_g; app_b = byp ? 256 : shd_b;
      mdl_pend = 1'b0;
    end else if (byp) begin
      app_r = 256; app_g = 256; app_b = 256;
    end
    chk_gains(byp ? "commit_byp" : "commit");
    chk("pend_after_commit", o_pending, 0);
    i_vsync = 1'b0;
    i_bypass = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int r, g, b;
    rst = 1'b1; i_vsync = 1'b0; i_sum_valid = 1'b0; i_bypass = 1'b0;
    i_r_sum = '0; i_g_sum = '0; i_b_sum = '0;
    repeat (3) @(negedge clk);
    chk_gains("reset");
    chk("reset_busy", o_busy, 0);
    chk("reset_pend", o_pending, 0);
    chk("reset_ovr", o_overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(128, 128, 128, 0, 0);
    commit(0);
    run_frame(64, 128, 192, 0, 0);
    commit(0);
    run_frame(0, 100, 100, 0, 0);
    commit(0);

    // Overlapping valid at cycle 30 must not disturb the running frame.
    run_frame(200, 50, 90, 30, 0);
    commit(0);

    // Edge coinciding with DONE is ignored; the following edge commits (bypassed).
    run_frame(30, 60, 90, 0, 1);
    commit(1);
    run_frame(90, 60, 30, 0, 0);
    commit(0);
    commit(1);

    for (int n = 0; n < 10; n++) begin
      r = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 255);
      g = $urandom_range(0, 255);
      b = $urandom_range(1, 255);
      run_frame(r, g, b, 0, 0);
      if ($urandom_range(0, 3) != 0) commit($urandom_range(0, 3) == 0);
    end
    commit(0);

    // Reset partway through a computation with a set already pending.
    run_frame(40, 80, 120, 0, 0);
    i_r_sum = mk_sum(10); i_g_sum = mk_sum(20); i_b_sum = mk_sum(30);
    i_sum_valid = 1'b1;
    @(negedge clk);
    i_sum_valid = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    #1;
    app_r = 256; app_g = 256; app_b = 256; mdl_pend = 1'b0; mdl_ovr = 1'b0;
    chk_gains("midrst");
    chk("midrst_busy", o_busy, 0);
    chk("midrst_pend", o_pending, 0);
    chk("midrst_ovr", o_overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(64, 128, 192, 0, 0);
    commit(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
